wm_phase_timer: RTL and testbench
=================================

WM_PHASE_TIMER -- requirements
Module: wm_phase_timer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clock cycles per one-second tick (minimum 2).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to load load_value and begin counting.
REQ-005 load_value  input  8  phase duration in seconds, 0..255.
REQ-006 pause  input  1  level; high freezes countdown.
REQ-007 abort  input  1  one-cycle synchronous cancel.
REQ-008 remaining  output  8  registered seconds left, binary.
REQ-009 busy  output  1  high in RUN or PAUSED.
REQ-010 done  output  1  one-cycle pulse at phase completion.
REQ-011 timer_display  output  8  registered display value of remaining.

Function
REQ-012 FSM states IDLE, RUN, PAUSED; all outputs registered.
REQ-013 Per-edge input priority: abort > start > pause > tick.
REQ-014 abort in any state: next state IDLE, remaining=0, prescaler=0, done stays 0.
REQ-015 start with load_value>0, any state: RUN, remaining=load_value, prescaler=0; a start during RUN or PAUSED restarts the phase.
REQ-016 start with load_value==0: stay/go IDLE, remaining=0, done=1 for the next cycle only.
REQ-017 RUN: prescaler counts 0..TICK_DIV-1 and wraps to 0; on the wrap edge remaining decrements by 1.
REQ-018 On the wrap edge with remaining==1: remaining=0, done=1 for one cycle, state IDLE.
REQ-019 Start-to-done latency: done first high exactly load_value*TICK_DIV cycles after the edge that sampled start, excluding paused cycles.
REQ-020 RUN with pause=1 (no abort/start): PAUSED; prescaler and remaining held.
REQ-021 PAUSED with pause=0: RUN, prescaler resumes from its held value, no count lost or repeated.
REQ-022 pause in IDLE has no effect; remaining never wraps below 0.
REQ-023 timer_display updates on the same edge as remaining.

Reset
REQ-024 rst low: state IDLE, prescaler=0, remaining=0, busy=0, done=0, timer_display=0, immediately and independent of clk.
REQ-025 Reset asserted mid-phase discards the phase; no done is issued after release.

Configuration
REQ-026 WM_TIMER_BCD_EN defined: timer_display = two BCD digits of min(remaining,99), tens in [7:4], ones in [3:0].
REQ-027 WM_TIMER_BCD_EN undefined: timer_display = remaining, binary; no BCD logic synthesised.

Structure
REQ-028 Shared package wm_pkg holds the timer state encoding, the TICK_DIV default and the 8-bit duration width constant.
REQ-029 Prescaler lives in sub-module wm_tick_prescaler (inputs clk, rst, enable, clear; output tick, one cycle on wrap).

Verification (TICK_DIV=4)
REQ-030 load_value=3, start -> busy high, remaining 3,2,1,0 at 4-cycle steps, done single pulse 12 cycles after start, then IDLE.
REQ-031 load_value=2, start, pause high cycles 5..14 -> remaining held at 1 throughout, done at cycle 18.
REQ-032 load_value=5, abort at cycle 6 -> remaining=0, busy=0, no done ever; simultaneous start+abort -> IDLE.
REQ-033 load_value=0, start -> done high exactly one cycle, busy never high.
REQ-034 load_value=57 -> timer_display 0x57 (BCD) / 0x39 (binary); load_value=150 -> 0x99 (BCD) / 0x96 (binary).
REQ-035 rst low at cycle 7 of a 3-second phase -> all outputs 0 asynchronously; no done after release.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared state encoding, duration width and tick-rate default for the phase timer.
// Build option WM_TIMER_BCD_EN adds the BCD display formatter.
package wm_pkg;

  localparam int TICK_DIV_DEFAULT = 50_000_000;
  localparam int DUR_W            = 8;

  typedef logic [DUR_W-1:0] dur_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } timer_state_e;

`ifdef WM_TIMER_BCD_EN
  // Values above 99 saturate so the two-digit display never shows garbage.
  function automatic dur_t to_bcd(input dur_t value);
    dur_t clamped;
    clamped = (value > dur_t'(99)) ? dur_t'(99) : value;
    return {4'(clamped / dur_t'(10)), 4'(clamped % dur_t'(10))};
  endfunction
`endif

endpackage

// File: rtl/wm_phase_timer_if.sv
// Control and status bundle between the phase sequencer (master) and the timer (slave).
interface wm_phase_timer_if;
  import wm_pkg::*;

  logic start;
  dur_t load_value;
  logic pause;
  logic abort;
  dur_t remaining;
  logic busy;
  logic done;
  dur_t timer_display;

  modport master (
    output start, load_value, pause, abort,
    input  remaining, busy, done, timer_display
  );

  modport slave (
    input  start, load_value, pause, abort,
    output remaining, busy, done, timer_display
  );

endinterface

// File: rtl/wm_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
module wm_tick_prescaler #(
  parameter int TICK_DIV = wm_pkg::TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  // Combinational so the owner acts on the very edge the count wraps.
  assign tick = enable && !clear && (r_count == CNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == CNT_MAX) ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/wm_phase_timer.sv
// Washing-machine phase countdown: IDLE/RUN/PAUSED with one-second ticks.
// Build option WM_TIMER_BCD_EN: timer_display shows BCD instead of binary.
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  wm_phase_timer_if.slave     bus
);

  timer_state_e r_state;
  dur_t         r_remaining;
  dur_t         r_display;
  logic         r_busy;
  logic         r_done;

  logic w_enable;
  logic w_clear;
  logic w_tick;
  dur_t w_rem_next;
  dur_t w_disp_next;

  // Counting stops on any higher-priority request; a resume edge still counts.
  assign w_enable = (r_state != ST_IDLE) && !bus.pause && !bus.abort && !bus.start;
  assign w_clear  = bus.abort || bus.start;

  wm_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (w_enable),
    .clear  (w_clear),
    .tick   (w_tick)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_rem_next = r_remaining;
    if (bus.abort) begin
      w_rem_next = '0;
    end else if (bus.start) begin
      w_rem_next = bus.load_value;
    end else if (w_tick && (r_remaining != '0)) begin
      w_rem_next = r_remaining - 1'b1;
    end
  end

`ifdef WM_TIMER_BCD_EN
  assign w_disp_next = to_bcd(w_rem_next);
`else
  assign w_disp_next = w_rem_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_display   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_remaining <= w_rem_next;
      r_display   <= w_disp_next;
      if (bus.abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else if (bus.start) begin
        if (bus.load_value != '0) begin
          r_state <= ST_RUN;
          r_busy  <= 1'b1;
        end else begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_busy <= 1'b0;
          end
          ST_RUN, ST_PAUSED: begin
            if (bus.pause) begin
              r_state <= ST_PAUSED;
            end else if (w_tick && (r_remaining == dur_t'(1))) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.remaining     = r_remaining;
  assign bus.timer_display = r_display;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Directed bench for wm_phase_timer at TICK_DIV=4: vector table plus corner sequences.
module tb_wm_phase_timer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  wm_phase_timer_if bus_if ();

  wm_phase_timer #(.TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [7:0] load;
    logic       pause;
    logic       abort;
    logic [7:0] rem;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int s, input int l, input int p, input int a,
                              input int r, input int b, input int d);
    vec_t v;
    v.start = 1'(s);
    v.load  = 8'(l);
    v.pause = 1'(p);
    v.abort = 1'(a);
    v.rem   = 8'(r);
    v.busy  = 1'(b);
    v.done  = 1'(d);
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.start      = 1'b0;
    bus_if.load_value = 8'd0;
    bus_if.pause      = 1'b0;
    bus_if.abort      = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rem"},  32'(bus_if.remaining),     32'd0);
    check({tag, ".busy"}, 32'(bus_if.busy),          32'd0);
    check({tag, ".done"}, 32'(bus_if.done),          32'd0);
    check({tag, ".disp"}, 32'(bus_if.timer_display), 32'd0);
  endtask

  logic [7:0] exp57;
  logic [7:0] exp150;
  logic       done_seen;
  logic       busy_seen;
  logic [7:0] exp_rem;

  initial begin
    n_tests = 0;
    n_fail  = 0;
`ifdef WM_TIMER_BCD_EN
    exp57  = 8'h57;
    exp150 = 8'h99;
`else
    exp57  = 8'h39;
    exp150 = 8'h96;
`endif

    // 3-second phase: one decrement every 4 edges, done on edge 12.
    add(1, 3, 0, 0, 3, 1, 0);
    for (int k = 1; k <= 11; k++) add(0, 0, 0, 0, (k < 4) ? 3 : (k < 8) ? 2 : 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    // Pause while idle does nothing.
    add(0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    // Zero-length phase: immediate one-cycle done, never busy.
    add(1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // Abort beats a simultaneous start.
    add(1, 5, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // Restart mid-phase must clear the prescaler.
    add(1, 5, 0, 0, 5, 1, 0);
    add(0, 0, 0, 0, 5, 1, 0);
    add(0, 0, 0, 0, 5, 1, 0);
    add(1, 2, 0, 0, 2, 1, 0);
    for (int k = 1; k <= 7; k++) add(0, 0, 0, 0, (k < 4) ? 2 : 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1);
    // Start wins over pause, then pause freezes the count.
    add(1, 4, 1, 0, 4, 1, 0);
    for (int k = 1; k <= 6; k++) add(0, 0, 1, 0, 4, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0);

    // Reset is asynchronous: outputs zero before any clock edge.
    rst = 1'b0;
    idle_inputs();
    #1;
    check_all_zero("reset");
    #12 rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      bus_if.start      = vecs[i].start;
      bus_if.load_value = vecs[i].load;
      bus_if.pause      = vecs[i].pause;
      bus_if.abort      = vecs[i].abort;
      tick();
      check($sformatf("vec%0d.rem", i),  32'(bus_if.remaining),     32'(vecs[i].rem));
      check($sformatf("vec%0d.busy", i), 32'(bus_if.busy),          32'(vecs[i].busy));
      check($sformatf("vec%0d.done", i), 32'(bus_if.done),          32'(vecs[i].done));
      check($sformatf("vec%0d.disp", i), 32'(bus_if.timer_display), 32'(vecs[i].rem));
    end
    idle_inputs();
    tick();

    // Pause over edges 5..14 of a 2-second phase: done lands on edge 18.
    bus_if.start      = 1'b1;
    bus_if.load_value = 8'd2;
    tick();
    idle_inputs();
    for (int c = 1; c <= 19; c++) begin
      bus_if.pause = (c >= 5 && c <= 14);
      tick();
      exp_rem = (c < 4) ? 8'd2 : (c < 18) ? 8'd1 : 8'd0;
      check($sformatf("pause.c%0d.rem", c),  32'(bus_if.remaining), 32'(exp_rem));
      check($sformatf("pause.c%0d.done", c), 32'(bus_if.done),      32'(c == 18));
      check($sformatf("pause.c%0d.busy", c), 32'(bus_if.busy),      32'(c < 18));
    end
    idle_inputs();

    // Abort on edge 6 of a 5-second phase: no done afterwards.
    bus_if.start      = 1'b1;
    bus_if.load_value = 8'd5;
    tick();
    idle_inputs();
    for (int c = 1; c <= 5; c++) tick();
    check("abort.pre.rem", 32'(bus_if.remaining), 32'd4);
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    check_all_zero("abort");
    done_seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      done_seen = done_seen | bus_if.done;
    end
    check("abort.no_done", 32'(done_seen), 32'd0);

    // Display formatting for two-digit and saturating values.
    bus_if.start      = 1'b1;
    bus_if.load_value = 8'd57;
    tick();
    idle_inputs();
    check("disp57.rem",  32'(bus_if.remaining),     32'd57);
    check("disp57.disp", 32'(bus_if.timer_display), 32'(exp57));
    bus_if.start      = 1'b1;
    bus_if.load_value = 8'd150;
    tick();
    idle_inputs();
    check("disp150.rem",  32'(bus_if.remaining),     32'd150);
    check("disp150.disp", 32'(bus_if.timer_display), 32'(exp150));
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    check_all_zero("disp.abort");

    // Reset mid-phase, between edges: immediate clear, phase discarded.
    bus_if.start      = 1'b1;
    bus_if.load_value = 8'd3;
    tick();
    idle_inputs();
    for (int c = 1; c <= 6; c++) tick();
    check("rstmid.pre.rem", 32'(bus_if.remaining), 32'd2);
    #2 rst = 1'b0;
    #1;
    check_all_zero("rstmid");
    tick();
    tick();
    #2 rst = 1'b1;
    done_seen = 1'b0;
    busy_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      done_seen = done_seen | bus_if.done;
      busy_seen = busy_seen | bus_if.busy;
    end
    check("rstmid.no_done", 32'(done_seen), 32'd0);
    check("rstmid.no_busy", 32'(busy_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
